// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing the CLINT IOb slave port between N_MASTERS requesters.
// The winning request is registered onto s_*; the winner alone gets a one-cycle ready pulse.
module iob_clint_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned STRB_W   = DATA_W / 8,
    localparam int unsigned ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0] m_address,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0] m_wstrb,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [N_MASTERS-1:0]        m_ready,
    output logic                        s_valid,
    output logic [ADDR_W-1:0]           s_address,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [STRB_W-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]           s_rdata,
    input  logic                        s_ready,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e state_q, state_d;

    logic                 s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]    s_address_q, s_address_d;
    logic [DATA_W-1:0]    s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0]    s_wstrb_q, s_wstrb_d;
    logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;
    logic [N_MASTERS-1:0] m_ready_q, m_ready_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      winner;
    logic                 hit;

    // Round-robin pick: masters above last first, then wrap around to those at or below it.
    always_comb begin
        winner = last_q;
        hit    = 1'b0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (!hit && m_valid[i] && (ID_W'(i) > last_q)) begin
                winner = ID_W'(i);
                hit    = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (!hit && m_valid[i] && (ID_W'(i) <= last_q)) begin
                winner = ID_W'(i);
                hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hit) state_d = StBusy;
            StBusy:  if (s_ready) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_valid_d   = s_valid_q;
        s_address_d = s_address_q;
        s_wdata_d   = s_wdata_q;
        s_wstrb_d   = s_wstrb_q;
        m_rdata_d   = m_rdata_q;
        m_ready_d   = '0;
        grant_d     = grant_q;
        last_d      = last_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    s_valid_d = 1'b1;
                    grant_d   = winner;
                    last_d    = winner;
                    for (int i = 0; i < int'(N_MASTERS); i++) begin
                        if (ID_W'(i) == winner) begin
                            s_address_d = m_address[i*ADDR_W +: ADDR_W];
                            s_wdata_d   = m_wdata[i*DATA_W +: DATA_W];
                            s_wstrb_d   = m_wstrb[i*STRB_W +: STRB_W];
                        end
                    end
                end
            end
            StBusy: begin
                if (s_ready) begin
                    // Writes capture s_rdata too; masters ignore it.
                    m_rdata_d = s_rdata;
                    s_valid_d = 1'b0;
                    for (int i = 0; i < int'(N_MASTERS); i++) begin
                        if (ID_W'(i) == grant_q) m_ready_d[i] = 1'b1;
                    end
                end
            end
            StResp:  ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid_q   <= 1'b0;
            s_address_q <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            m_rdata_q   <= '0;
            m_ready_q   <= '0;
            grant_q     <= '0;
            last_q      <= ID_W'(N_MASTERS - 1);
        end else begin
            s_valid_q   <= s_valid_d;
            s_address_q <= s_address_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            m_rdata_q   <= m_rdata_d;
            m_ready_q   <= m_ready_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    assign s_valid   = s_valid_q;
    assign s_address = s_address_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign m_rdata   = m_rdata_q;
    assign m_ready   = m_ready_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_iob_clint_arbiter.sv
// Scoreboard bench: a transaction-level round-robin model predicts grants and responses,
// a negedge monitor compares them; a second 2-master instance checks steady contention.
`timescale 1ns/1ps
module tb_iob_clint_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        int   master;
        req_t r;
    } grant_t;

    typedef struct {
        logic [N-1:0]  ready;
        logic [DW-1:0] rdata;
    } resp_t;

    typedef struct {
        int            wt;
        logic [DW-1:0] rdata;
    } plan_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_valid = '0;
    logic [N*AW-1:0] m_address = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_wstrb = '0;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_rdata = '0;
    logic            s_ready = 1'b0;
    logic            busy;
    logic [IW-1:0]   grant_id;

    iob_clint_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .busy(busy), .grant_id(grant_id)
    );

    // Two-master instance: both request forever, slave always ready.
    logic [1:0]    m_valid2 = 2'b11;
    logic [2*AW-1:0] m_address2 = {16'h0200, 16'h0100};
    logic [2*DW-1:0] m_wdata2 = '0;
    logic [2*SW-1:0] m_wstrb2 = '0;
    logic [DW-1:0] m_rdata2;
    logic [1:0]    m_ready2;
    logic          s_valid2;
    logic [AW-1:0] s_address2;
    logic [DW-1:0] s_wdata2;
    logic [SW-1:0] s_wstrb2;
    logic [DW-1:0] s_rdata2 = 32'h5A5A_0001;
    logic          s_ready2 = 1'b1;
    logic          busy2;
    logic          grant_id2;

    iob_clint_arbiter #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
        .clk(clk), .rst(rst),
        .m_valid(m_valid2), .m_address(m_address2), .m_wdata(m_wdata2), .m_wstrb(m_wstrb2),
        .m_rdata(m_rdata2), .m_ready(m_ready2),
        .s_valid(s_valid2), .s_address(s_address2), .s_wdata(s_wdata2), .s_wstrb(s_wstrb2),
        .s_rdata(s_rdata2), .s_ready(s_ready2),
        .busy(busy2), .grant_id(grant_id2)
    );

    int n_chk = 0;
    int n_err = 0;

    req_t   req_q[N][$];
    plan_t  plan_q[$];
    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     got_grants[$];
    req_t   cur[N];
    logic [N-1:0] act = '0;
    int ph = 0;
    int last_sv_len = 0;
    int pulses2 = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] t;
        t = '0;
        t[w] = 1'b1;
        return t;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int grant_at(input int k);
        if (k >= 0 && k < got_grants.size()) return got_grants[k];
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += req_q[i].size();
        return s;
    endfunction

    task automatic push_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        req_t r;
        r.addr = a;
        r.wdata = d;
        r.wstrb = s;
        req_q[m].push_back(r);
    endtask

    task automatic push_plan(input int wt, input logic [DW-1:0] rd);
        plan_t p;
        p.wt = wt;
        p.rdata = rd;
        plan_q.push_back(p);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(ph == 0 && act == '0 && pending() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: model still busy after %0d cycles", budget);
        end
    endtask

    // Masters, CLINT slave and the reference model, all advanced once per clock.
    initial begin : driver
        int w, wnr, last, wt;
        logic [DW-1:0] plan_rd;
        grant_t g;
        resp_t rs;
        plan_t p;
        wnr = 0; last = N - 1; wt = 0; plan_rd = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                ph = 0;
                last = N - 1;
                act = '0;
                for (int i = 0; i < N; i++) req_q[i].delete();
                plan_q.delete();
                grant_q.delete();
                resp_q.delete();
            end else begin
                case (ph)
                    0: begin
                        w = rr_pick(act, last);
                        if (w >= 0) begin
                            wnr = w;
                            last = w;
                            ph = 1;
                            g.master = w;
                            g.r = cur[w];
                            grant_q.push_back(g);
                            if (plan_q.size() != 0) begin
                                p = plan_q.pop_front();
                                wt = p.wt;
                                plan_rd = p.rdata;
                            end else begin
                                wt = $urandom_range(0, 3);
                                plan_rd = $urandom;
                            end
                        end
                    end
                    1: if (s_ready) begin
                        rs.ready = onehot(wnr);
                        rs.rdata = plan_rd;
                        resp_q.push_back(rs);
                        ph = 2;
                    end
                    default: begin
                        ph = 0;
                        act[wnr] = 1'b0;
                    end
                endcase
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst && !act[i] && req_q[i].size() != 0) begin
                    cur[i] = req_q[i].pop_front();
                    act[i] = 1'b1;
                end
                if (act[i]) begin
                    m_address[i*AW +: AW] = cur[i].addr;
                    m_wdata[i*DW +: DW]   = cur[i].wdata;
                    m_wstrb[i*SW +: SW]   = cur[i].wstrb;
                end else begin
                    m_address[i*AW +: AW] = AW'($urandom);
                    m_wdata[i*DW +: DW]   = $urandom;
                    m_wstrb[i*SW +: SW]   = SW'($urandom);
                end
            end
            m_valid = act;
            if (ph == 1) begin
                s_ready = (wt == 0);
                if (wt > 0) wt--;
                s_rdata = s_ready ? plan_rd : $urandom;
            end else begin
                s_ready = 1'b0;
                s_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        grant_t cg;
        resp_t  er;
        logic   prev_sv;
        int     sv_len;
        logic [DW-1:0] exp_rd;
        prev_sv = 1'b0; sv_len = 0; exp_rd = '0;
        cg.master = -1; cg.r.addr = '0; cg.r.wdata = '0; cg.r.wstrb = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_s_valid", s_valid, 0);
                chk("rst_m_ready", m_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_m_rdata", m_rdata, 0);
                prev_sv = 1'b0;
                exp_rd = '0;
            end else begin
                chk("phase_s_valid", s_valid, ph == 1);
                chk("phase_m_ready", m_ready != '0, ph == 2);
                chk("phase_busy", busy, ph != 0);
                if (s_valid) begin
                    if (!prev_sv) begin
                        if (grant_q.size() == 0) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL unexpected_grant: s_valid rose with no grant predicted");
                        end else begin
                            cg = grant_q.pop_front();
                        end
                        sv_len = 0;
                    end
                    sv_len++;
                    chk("s_address", s_address, cg.r.addr);
                    chk("s_wdata", s_wdata, cg.r.wdata);
                    chk("s_wstrb", s_wstrb, cg.r.wstrb);
                    chk("grant_id", grant_id, cg.master);
                end
                prev_sv = s_valid;
                if (m_ready != '0) begin
                    if (resp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_ready: m_ready=%0b with no response due", m_ready);
                    end else begin
                        er = resp_q.pop_front();
                        chk("m_ready", m_ready, er.ready);
                        chk("m_rdata", m_rdata, er.rdata);
                        exp_rd = er.rdata;
                    end
                    last_sv_len = sv_len;
                    got_grants.push_back(oh_idx(m_ready));
                end else begin
                    chk("m_rdata_hold", m_rdata, exp_rd);
                end
            end
        end
    end

    initial begin : monitor2
        int k, cyc, last_cyc;
        k = 0; cyc = 0; last_cyc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                k = 0;
                last_cyc = -1;
            end else if (m_ready2 != 2'b00) begin
                chk("c2_m_ready", m_ready2, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("c2_grant_id", grant_id2, k % 2);
                chk("c2_s_address", s_address2, (k % 2 == 0) ? 16'h0100 : 16'h0200);
                chk("c2_m_rdata", m_rdata2, 32'h5A5A_0001);
                if (last_cyc >= 0) chk("c2_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                k++;
                pulses2++;
            end
        end
    end

    initial begin : control
        int base, cnt, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset_s_valid", s_valid, 0);
        chk("reset_s_address", s_address, 0);
        chk("reset_s_wdata", s_wdata, 0);
        chk("reset_s_wstrb", s_wstrb, 0);
        chk("reset_m_rdata", m_rdata, 0);
        chk("reset_m_ready", m_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_grant_id", grant_id, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single read from master 1.
        base = got_grants.size();
        push_req(1, 16'h4000, $urandom, 4'h0);
        push_plan(0, 32'h1234_5678);
        wait_idle(50);
        chk("read_count", got_grants.size(), base + 1);
        chk("read_winner", grant_at(base), 1);
        chk("read_m_rdata", m_rdata, 32'h1234_5678);
        chk("read_busy_len", last_sv_len, 1);

        // Single write from master 0 to msip.
        base = got_grants.size();
        push_req(0, 16'h0000, 32'hDEAD_BEEF, 4'hF);
        push_plan(0, $urandom);
        wait_idle(50);
        chk("write_count", got_grants.size(), base + 1);
        chk("write_winner", grant_at(base), 0);

        // Slave wait states.
        base = got_grants.size();
        push_req(2, 16'h4008, $urandom, 4'h0);
        push_plan(5, 32'hCAFE_F00D);
        wait_idle(60);
        chk("wait_winner", grant_at(base), 2);
        chk("wait_busy_len", last_sv_len, 6);
        chk("wait_m_rdata", m_rdata, 32'hCAFE_F00D);

        // Wrap-around after a grant to master 2.
        base = got_grants.size();
        push_req(0, 16'h4010, $urandom, 4'h0);
        push_req(1, 16'h4018, $urandom, 4'h3);
        wait_idle(60);
        chk("wrap_first", grant_at(base), 0);
        chk("wrap_second", grant_at(base + 1), 1);

        // After a grant to master 1, master 2 outranks master 0.
        base = got_grants.size();
        push_req(2, 16'h4020, $urandom, 4'h0);
        push_req(0, 16'h4028, $urandom, 4'h0);
        wait_idle(60);
        chk("wrap2_first", grant_at(base), 2);
        chk("wrap2_second", grant_at(base + 1), 0);

        // Reset while BUSY.
        push_req(1, 16'h4030, $urandom, 4'h0);
        push_plan(10, $urandom);
        n = 0;
        while (ph != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_busy", ph, 1);
        @(negedge clk);
        base = got_grants.size();
        #2;
        rst = 1'b0;
        #1;
        chk("abort_s_valid", s_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_m_ready", m_ready, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_ready", got_grants.size(), base);

        // Contention from reset: masters 0 and 1 always requesting.
        #2;
        rst = 1'b1;
        base = got_grants.size();
        for (int j = 0; j < 3; j++) begin
            push_req(0, 16'h4000 + 16'(j), $urandom, 4'h0);
            push_req(1, 16'h4100 + 16'(j), $urandom, 4'hF);
        end
        wait_idle(200);
        for (int j = 0; j < 6; j++) chk("contention_order", grant_at(base + j), j % 2);

        // Random traffic.
        base = got_grants.size();
        cnt = 0;
        for (int t = 0; t < 60; t++) begin
            push_req($urandom_range(0, N - 1), AW'($urandom), $urandom,
                     ($urandom_range(0, 1) != 0) ? SW'($urandom) : 4'h0);
            cnt++;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle(3000);
        chk("random_resp_count", got_grants.size() - base, cnt);

        chk("grant_q_drained", grant_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("c2_pulses_seen", pulses2 >= 6, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "time limit");
    end

endmodule
